// File: rtl/data_mem_be_pkg.sv
// Shared types and decode helpers for the byte-enabled MEM-stage data memory.
package data_mem_be_pkg;

  localparam logic [1:0] MEM_SZ_B = 2'b00;
  localparam logic [1:0] MEM_SZ_H = 2'b01;
  localparam logic [1:0] MEM_SZ_W = 2'b10;
  localparam logic [1:0] MEM_SZ_R = 2'b11;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
  } ld_meta_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic r;
    unique case (size)
      MEM_SZ_B: r = 1'b0;
      MEM_SZ_H: r = off[0];
      MEM_SZ_W: r = |off;
      default:  r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_en(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] r;
    unique case (size)
      MEM_SZ_B: r = 4'b0001 << off;
      MEM_SZ_H: r = off[1] ? 4'b1100 : 4'b0011;
      MEM_SZ_W: r = 4'b1111;
      default:  r = 4'b0000;
    endcase
    return r;
  endfunction

  // Replicate sub-word data so every lane sees its own copy.
  function automatic logic [31:0] lane_data(
    input logic [1:0]  size,
    input logic [31:0] d
  );
    logic [31:0] r;
    unique case (size)
      MEM_SZ_B: r = {4{d[7:0]}};
      MEM_SZ_H: r = {2{d[15:0]}};
      default:  r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract(
    input logic [31:0] word,
    input ld_meta_t    m
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{m.off, 3'b000} +: 8];
    h = m.off[1] ? word[31:16] : word[15:0];
    unique case (m.size)
      MEM_SZ_B: r = m.uns ? {24'b0, b} : {{24{b[7]}}, b};
      MEM_SZ_H: r = m.uns ? {16'b0, h} : {{16{h[15]}}, h};
      default:  r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_be_byte_lane_ram.sv
// Four 8-bit lanes with per-lane write enable and a registered read port.
module data_mem_be_byte_lane_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we_i[l]) mem_q[addr_i] <= wdata_i[8*l +: 8];
    end

    // Read register only moves on a load so the result can be held.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rd_q <= '0;
      else if (re_i) rd_q <= mem_q[addr_i];
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/data_mem_be.sv
// MEM-stage data memory: byte enables, extended sub-word loads,
// misalignment flagging, pipelined read and post-reset clear.
module data_mem_be
  import data_mem_be_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        misalign,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;

  logic          acc, bad, st_go, ld_go;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wd, ram_rd;

  ld_meta_t      m1_q;
  logic          v1_q, mis_q;
  logic [31:0]   ext1;
  logic          unused;

  assign unused = ^address[31:AW+2];

  assign acc   = req_valid && req_ready;
  assign bad   = misaligned(req_size, address[1:0]);
  assign st_go = acc && req_we && !bad;
  assign ld_go = acc && !req_we && !bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (&clr_q) state_d = ST_RUN;
      end
      ST_RUN: clr_d = '0;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    req_ready = 1'b0;
    unique case (state_q)
      ST_CLEAR: busy      = 1'b1;
      ST_RUN:   req_ready = 1'b1;
      default:  busy      = 1'b1;
    endcase
  end

  // The clear sweep owns the RAM port; no requests are accepted then.
  always_comb begin
    ram_addr = address[AW+1:2];
    ram_we   = st_go ? lane_en(req_size, address[1:0]) : 4'b0000;
    ram_wd   = lane_data(req_size, data_in);
    if (busy) begin
      ram_addr = clr_q;
      ram_we   = 4'b1111;
      ram_wd   = '0;
    end
  end

  data_mem_be_byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (ram_addr),
    .we_i   (ram_we),
    .wdata_i(ram_wd),
    .re_i   (ld_go),
    .rdata_o(ram_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_q  <= '0;
      v1_q  <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      v1_q  <= ld_go;
      mis_q <= acc && bad;
      if (ld_go) begin
        m1_q <= '{off:  address[1:0],
                  size: req_size,
                  uns:  req_unsigned};
      end
    end
  end

  assign ext1     = extract(ram_rd, m1_q);
  assign misalign = mis_q;

  if (READ_LAT == 2) begin : g_lat2
    logic        v2_q;
    logic [31:0] d2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= ext1;
      end
    end

    assign rsp_valid = v2_q;
    assign rsp_data  = d2_q;
  end else begin : g_lat1
    assign rsp_valid = v1_q;
    assign rsp_data  = ext1;
  end

endmodule

// File: tb/tb_data_mem_be.sv
// Directed self-checking bench for data_mem_be (DEPTH_WORDS=16, READ_LAT=2).
module tb_data_mem_be;

  localparam int         DW   = 16;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        misalign;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_be #(
    .DEPTH_WORDS(DW),
    .READ_LAT   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .address     (address),
    .data_in     (data_in),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .misalign    (misalign),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    address      = a;
    data_in      = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    drive(1'b1, 1'b1, sz, 1'b0, a, d);
    tick();
    idle();
    check("store_no_misalign", {31'b0, misalign}, 32'h0);
  endtask

  task automatic load(input string tag, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a,
                      input logic [31:0] exp);
    drive(1'b1, 1'b0, sz, uns, a, 32'h0);
    tick();
    idle();
    check({tag, "_early"}, {31'b0, rsp_valid}, 32'h0);
    tick();
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'h1);
    check({tag, "_data"}, rsp_data, exp);
  endtask

  task automatic bad_access(input string tag, input logic we,
                            input logic [1:0] sz, input logic [31:0] a);
    drive(1'b1, we, sz, 1'b0, a, 32'h12);
    tick();
    idle();
    check({tag, "_pulse"}, {31'b0, misalign}, 32'h1);
    check({tag, "_norsp0"}, {31'b0, rsp_valid}, 32'h0);
    tick();
    check({tag, "_drop"}, {31'b0, misalign}, 32'h0);
    check({tag, "_norsp1"}, {31'b0, rsp_valid}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;

    // Reset values
    tick();
    tick();
    check("rst_ready", {31'b0, req_ready}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'h0);

    // Clear duration
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    check("clear_cycles", n, DW);
    check("run_busy", {31'b0, busy}, 32'h0);

    for (int i = 0; i < DW; i++)
      load($sformatf("clr_w%0d", i), SZ_W, 1'b0, 32'(4 * i), 32'h0);

    // Sub-word stores
    store(SZ_W, 32'h10, 32'h11223344);
    store(SZ_B, 32'h12, 32'h000000AB);
    store(SZ_H, 32'h10, 32'h0000BEEF);
    load("merge", SZ_W, 1'b0, 32'h10, 32'h11ABBEEF);

    // Extension
    store(SZ_W, 32'h20, 32'h80FF7F01);
    load("lb21", SZ_B, 1'b0, 32'h21, 32'h0000007F);
    load("lb23", SZ_B, 1'b0, 32'h23, 32'hFFFFFF80);
    load("lbu22", SZ_B, 1'b1, 32'h22, 32'h000000FF);
    load("lh22", SZ_H, 1'b0, 32'h22, 32'hFFFF80FF);
    load("lhu22", SZ_H, 1'b1, 32'h22, 32'h000080FF);
    load("lb20", SZ_B, 1'b0, 32'h20, 32'h00000001);
    load("lh20", SZ_H, 1'b0, 32'h20, 32'h00007F01);

    // Misalignment
    store(SZ_W, 32'h04, 32'hCAFEF00D);
    bad_access("mis_sw06", 1'b1, SZ_W, 32'h06);
    bad_access("mis_lh03", 1'b0, SZ_H, 32'h03);
    bad_access("mis_sz11", 1'b0, SZ_R, 32'h08);
    bad_access("mis_sz11_st", 1'b1, SZ_R, 32'h04);
    load("mis_word04", SZ_W, 1'b0, 32'h04, 32'hCAFEF00D);

    // Back-to-back loads
    for (int i = 0; i < 4; i++)
      store(SZ_W, 32'(4 * i), 32'hA0000000 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 1'b0, SZ_W, 1'b0, 32'(4 * i), 32'h0);
      else idle();
      tick();
      if (i >= 1 && i <= 4) begin
        check($sformatf("pipe_v%0d", i), {31'b0, rsp_valid}, 32'h1);
        check($sformatf("pipe_d%0d", i), rsp_data,
              32'hA0000000 + 32'(i - 1));
      end else begin
        check($sformatf("pipe_v%0d", i), {31'b0, rsp_valid}, 32'h0);
      end
    end
    check("hold_data", rsp_data, 32'hA0000003);

    // Store then load of the same word on the next cycle
    drive(1'b1, 1'b1, SZ_W, 1'b0, 32'h24, 32'h5A5A1234);
    tick();
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h24, 32'h0);
    tick();
    idle();
    check("raw_early", {31'b0, rsp_valid}, 32'h0);
    tick();
    check("raw_valid", {31'b0, rsp_valid}, 32'h1);
    check("raw_data", rsp_data, 32'h5A5A1234);

    // Address wrap
    load("alias0", SZ_W, 1'b0, 32'(DW * 4), 32'hA0000000);
    store(SZ_B, 32'(DW * 4 + 5), 32'h00000077);
    load("alias_st", SZ_W, 1'b0, 32'h04, 32'hA0007701);

    // Reset with a load in flight
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h0C, 32'h0);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("mid_rsp", {31'b0, rsp_valid}, 32'h0);
    check("mid_busy", {31'b0, busy}, 32'h1);
    check("mid_ready", {31'b0, req_ready}, 32'h0);
    tick();
    check("mid_rsp2", {31'b0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    seen = 1'b0;
    while (busy && n < 100) begin
      tick();
      n++;
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_clear_cycles", n, DW);
    check("mid_no_rsp", {31'b0, seen}, 32'h0);
    load("mid_cleared", SZ_W, 1'b0, 32'h0C, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
